conv_window_sched: RTL and testbench

- Controller that sequences the convolution engine over one input feature map.
- On a start pulse it latches the layer configuration and walks output positions in raster order, with kernels in the inner loop.
- Issues one window command per (output row, output col, kernel) over a valid/ready handshake.
- Tracks outstanding commands against engine completions and signals done once every command has retired.

---
 rtl/conv_window_sched_pkg.sv | 15 +
 rtl/conv_window_sched_if.sv | 15 +
 rtl/conv_window_sched_axis_iter.sv | 28 ++
 rtl/conv_window_sched.sv | 102 ++++++++++
 tb/tb_conv_window_sched.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/conv_window_sched_pkg.sv
// conv_sched_pkg: shared types and default widths for the convolution window scheduler
package conv_sched_pkg;
  localparam int DEF_DIM_W = 16;
  localparam int DEF_KERN_W = 8;
  localparam int DEF_KS_W = 4;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int DEF_OUT_W = $clog2(DEF_MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef struct packed {
    logic [DEF_DIM_W-1:0] row_base;
    logic [DEF_DIM_W-1:0] col_base;
    logic [DEF_KERN_W-1:0] kernel;
    logic last;
  } cmd_t;
endpackage

// File: rtl/conv_window_sched_if.sv
// conv_window_sched_if: window command handshake toward the engine plus its completion return
interface conv_window_sched_if #(
  parameter int DIM_W = conv_sched_pkg::DEF_DIM_W,
  parameter int KERN_W = conv_sched_pkg::DEF_KERN_W
);
  logic cmd_valid;
  logic cmd_ready;
  logic [DIM_W-1:0] cmd_row_base;
  logic [DIM_W-1:0] cmd_col_base;
  logic [KERN_W-1:0] cmd_kernel;
  logic cmd_last;
  logic cmpl;
  modport master (output cmd_valid, cmd_row_base, cmd_col_base, cmd_kernel, cmd_last, input cmd_ready, cmpl);
  modport slave (input cmd_valid, cmd_row_base, cmd_col_base, cmd_kernel, cmd_last, output cmd_ready, cmpl);
endinterface

// File: rtl/conv_window_sched_axis_iter.sv
// conv_axis_iter: walks one window axis from 0 in stride steps, flagging the last window that still fits
module conv_axis_iter #(
  parameter int DIM_W = 16,
  parameter int KS_W = 4
) (
  input logic clk,
  input logic rst_n,
  input logic [KS_W-1:0] step,
  input logic [DIM_W-1:0] size,
  input logic [KS_W-1:0] ks,
  input logic advance,
  input logic clear,
  output logic [DIM_W-1:0] base,
  output logic is_last
);
  logic [DIM_W-1:0] base_q, base_d;
  logic [DIM_W:0] nxt;
  // one extra bit keeps base+step+ks from wrapping near the top of the range
  always_comb begin
    nxt = {1'b0, base_q} + (DIM_W+1)'(step);
    is_last = nxt + (DIM_W+1)'(ks) > {1'b0, size};
    base_d = clear ? '0 : advance ? (is_last ? '0 : nxt[DIM_W-1:0]) : base_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) base_q <= '0;
    else base_q <= base_d;
  assign base = base_q;
endmodule

// File: rtl/conv_window_sched.sv
// conv_window_sched: issues one window command per (row, col, kernel) in raster order
// and reports done once every issued command has been completed by the engine
module conv_window_sched
  import conv_sched_pkg::*;
#(
  parameter int DIM_W = DEF_DIM_W,
  parameter int KERN_W = DEF_KERN_W,
  parameter int KS_W = DEF_KS_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic [DIM_W-1:0] cfg_rows,
  input logic [DIM_W-1:0] cfg_cols,
  input logic [KS_W-1:0] cfg_kernel_size,
  input logic [KS_W-1:0] cfg_stride,
  input logic [KERN_W-1:0] cfg_num_kernels,
  conv_window_sched_if.master cmd,
  output logic busy,
  output logic done,
  output logic err
);
  state_t state_q, state_d;
  logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d, row_base, col_base;
  logic [KS_W-1:0] ks_q, ks_d, stride_q, stride_d;
  logic [KERN_W-1:0] nk_q, nk_d, kern_q, kern_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic err_q, err_d, done_q, done_d;
  logic accept, cfg_bad, valid, xfer, kern_last, col_last, row_last, last;
  always_comb begin
    accept = state_q == IDLE && start;
    cfg_bad = cfg_rows < DIM_W'(cfg_kernel_size) || cfg_cols < DIM_W'(cfg_kernel_size) ||
              cfg_kernel_size == '0 || cfg_stride == '0 || cfg_num_kernels == '0;
    valid = state_q == ISSUE && out_q < OUT_W'(MAX_OUTSTANDING);
    xfer = valid && cmd.cmd_ready;
    kern_last = kern_q == nk_q - KERN_W'(1);
    last = kern_last && col_last && row_last;
    rows_d = accept ? cfg_rows : rows_q;
    cols_d = accept ? cfg_cols : cols_q;
    ks_d = accept ? cfg_kernel_size : ks_q;
    stride_d = accept ? cfg_stride : stride_q;
    nk_d = accept ? cfg_num_kernels : nk_q;
    kern_d = accept ? '0 : xfer ? (kern_last ? '0 : kern_q + KERN_W'(1)) : kern_q;
    out_d = out_q + OUT_W'(xfer) - OUT_W'(cmd.cmpl && out_q != '0);
    err_d = accept ? cfg_bad : err_q;
    done_d = state_q == DONE;
  end
  conv_axis_iter #(.DIM_W(DIM_W), .KS_W(KS_W)) u_col (
    .clk(clk), .rst_n(rst_n), .step(stride_q), .size(cols_q), .ks(ks_q),
    .advance(xfer && kern_last), .clear(accept), .base(col_base), .is_last(col_last)
  );
  conv_axis_iter #(.DIM_W(DIM_W), .KS_W(KS_W)) u_row (
    .clk(clk), .rst_n(rst_n), .step(stride_q), .size(rows_q), .ks(ks_q),
    .advance(xfer && kern_last && col_last), .clear(accept), .base(row_base), .is_last(row_last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = cfg_bad ? DONE : ISSUE;
      ISSUE: if (xfer && last) state_d = WAIT;
      WAIT: if (out_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rows_q <= '0;
      cols_q <= '0;
      ks_q <= '0;
      stride_q <= '0;
      nk_q <= '0;
      kern_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rows_q <= rows_d;
      cols_q <= cols_d;
      ks_q <= ks_d;
      stride_q <= stride_d;
      nk_q <= nk_d;
      kern_q <= kern_d;
      out_q <= out_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  always_comb begin
    cmd.cmd_valid = valid;
    cmd.cmd_row_base = row_base;
    cmd.cmd_col_base = col_base;
    cmd.cmd_kernel = kern_q;
    cmd.cmd_last = last;
    busy = state_q != IDLE;
    done = done_q;
    err = err_q;
  end
endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: randomized handshake stimulus checked against a nested-loop window list
module tb_conv_window_sched;
  import conv_sched_pkg::*;
  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] cfg_rows = 0, cfg_cols = 0;
  logic [3:0] cfg_kernel_size = 0, cfg_stride = 0;
  logic [7:0] cfg_num_kernels = 0;
  logic busy, done, err;
  int n_cmp = 0, n_bad = 0, tb_out = 0;
  conv_window_sched_if bus ();
  conv_window_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .cfg_kernel_size(cfg_kernel_size), .cfg_stride(cfg_stride), .cfg_num_kernels(cfg_num_kernels),
    .cmd(bus), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cmd_t cur_cmd();
    return '{row_base: bus.cmd_row_base, col_base: bus.cmd_col_base, kernel: bus.cmd_kernel, last: bus.cmd_last};
  endfunction

  task automatic pulse_start(input int rows, input int cols, input int ks, input int st, input int nk);
    @(negedge clk);
    cfg_rows = 16'(rows);
    cfg_cols = 16'(cols);
    cfg_kernel_size = 4'(ks);
    cfg_stride = 4'(st);
    cfg_num_kernels = 8'(nk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_layer(input int rows, input int cols, input int ks, input int st, input int nk,
                           input int rdy_pct, input int cmpl_pct);
    cmd_t exp_q[$];
    cmd_t cur, held;
    logic held_v = 0;
    int n_total, n_got = 0, cyc = 0, first_x = -1, last_x = 0, limit;
    for (int r = 0; r + ks <= rows; r += st)
      for (int c = 0; c + ks <= cols; c += st)
        for (int k = 0; k < nk; k++)
          exp_q.push_back('{row_base: 16'(r), col_base: 16'(c), kernel: 8'(k), last: 1'b0});
    cur = exp_q.pop_back();
    cur.last = 1'b1;
    exp_q.push_back(cur);
    n_total = exp_q.size();
    limit = n_total * 12 + 200;
    pulse_start(rows, cols, ks, st, nk);
    chk("first_valid", bus.cmd_valid, 1);
    chk("busy", busy, 1);
    chk("err_clear", err, 0);
    while (cyc < limit && !done) begin
      cur = cur_cmd();
      if (held_v) begin
        chk("stall_valid", bus.cmd_valid, 1);
        chk("stall_hold", cur, held);
      end
      if (tb_out >= 8) chk("cap_valid", bus.cmd_valid, 0);
      cfg_rows = 16'($urandom);
      cfg_kernel_size = 4'($urandom);
      start = $urandom_range(15) == 0;
      bus.cmd_ready = $urandom_range(99) < rdy_pct;
      bus.cmpl = tb_out > 0 && $urandom_range(99) < cmpl_pct;
      if (bus.cmd_valid && bus.cmd_ready) begin
        n_got++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        if (exp_q.size() > 0) chk("cmd", cur, exp_q.pop_front());
      end
      held_v = bus.cmd_valid && !bus.cmd_ready;
      held = cur;
      tb_out = tb_out + int'(bus.cmd_valid && bus.cmd_ready) - int'(bus.cmpl);
      @(negedge clk);
      cyc++;
    end
    start = 0;
    bus.cmd_ready = 0;
    bus.cmpl = 0;
    chk("done_seen", done, 1);
    chk("done_idle", busy, 0);
    chk("drained", tb_out, 0);
    chk("cmd_count", n_got, n_total);
    chk("err_end", err, 0);
    if (rdy_pct == 100) chk("throughput", last_x - first_x, n_total - 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic run_bad(input int rows, input int ks, input int st, input int nk);
    pulse_start(rows, 20, ks, st, nk);
    chk("bad_busy", busy, 1);
    chk("bad_err", err, 1);
    chk("bad_valid", bus.cmd_valid, 0);
    @(negedge clk);
    chk("bad_done", done, 1);
    chk("bad_idle", busy, 0);
    @(negedge clk);
    chk("bad_done_pulse", done, 0);
    chk("err_sticky", err, 1);
  endtask

  task automatic run_random(input int rdy_pct, input int cmpl_pct);
    int ks = $urandom_range(1, 4);
    run_layer($urandom_range(ks, 14), $urandom_range(ks, 14), ks, $urandom_range(1, 5),
              $urandom_range(1, 3), rdy_pct, cmpl_pct);
  endtask

  initial begin
    int n;
    bus.cmd_ready = 0;
    bus.cmpl = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {bus.cmd_valid, bus.cmd_row_base, bus.cmd_col_base, bus.cmd_kernel,
                       bus.cmd_last, busy, done, err}, 0);
    rst_n = 1;
    run_layer(20, 20, 3, 2, 1, 100, 100);
    run_layer(20, 20, 3, 1, 2, 100, 100);
    run_bad(2, 3, 1, 1);
    run_layer(6, 6, 2, 2, 1, 100, 100);
    run_bad(10, 3, 0, 1);
    run_bad(10, 0, 1, 1);
    run_layer(20, 20, 3, 2, 1, 60, 50);
    repeat (4) run_random($urandom_range(30, 90), $urandom_range(20, 90));
    pulse_start(20, 20, 3, 2, 1);
    bus.cmd_ready = 1;
    n = 0;
    repeat (20) begin
      if (bus.cmd_valid) n++;
      @(negedge clk);
    end
    chk("cap_count", n, 8);
    chk("cap_stop", bus.cmd_valid, 0);
    bus.cmpl = 1;
    @(negedge clk);
    chk("cmpl_frees", bus.cmd_valid, 1);
    @(negedge clk);
    chk("xfer_cmpl_hold", bus.cmd_valid, 1);
    chk("tenth_cmd", {bus.cmd_row_base, bus.cmd_col_base, bus.cmd_kernel}, {16'd2, 16'd0, 8'd0});
    bus.cmpl = 0;
    @(negedge clk);
    chk("refill_stop", bus.cmd_valid, 0);
    rst_n = 0;
    bus.cmpl = 1;
    #1;
    chk("abort_outs", {bus.cmd_valid, bus.cmd_row_base, bus.cmd_col_base, bus.cmd_kernel,
                       bus.cmd_last, busy, done, err}, 0);
    tb_out = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_abort", {busy, done}, 0);
    end
    bus.cmpl = 0;
    run_layer(9, 11, 3, 2, 2, 70, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
